// File: rtl/bram_stream_reader_pkg.sv
// Shared NTT read-out definitions: BRAM geometry defaults and the reader FSM encoding.
package bram_stream_reader_pkg;

    localparam int unsigned NTT_AW = 11;
    localparam int unsigned NTT_DW = 36;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Two-entry skid FIFO: the head register drives the stream directly, the tail absorbs one stall.
module stream_skid_fifo2 #(
    parameter int unsigned W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_dout,
    output logic [1:0]   o_cnt
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_head <= i_din;
                    else               r_tail <= i_din;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged: the incoming word lands behind whatever remains.
                    if (r_cnt == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end else begin
                        r_head <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (r_cnt != 2'd0);
    assign o_dout  = r_head;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/bram_stream_reader.sv
// Sweeps a contiguous BRAM address window and streams the words out on valid/ready,
// hiding the BRAM's one-cycle read latency behind a 2-entry skid FIFO.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned AW = NTT_AW,
    parameter int unsigned DW = NTT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    state_e        r_state;
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_remaining;
    logic          r_inflight;
    logic          r_inflight_last;
    logic          r_busy;
    logic          r_done;

    logic          w_valid;
    logic          w_pop;
    logic [1:0]    w_cnt;
    logic [2:0]    w_occ;
    logic          w_issue;
    logic [DW:0]   w_head;

    // Occupancy after this cycle's pop, counting the read already in flight.
    assign w_pop   = w_valid && m_ready;
    assign w_occ   = 3'(w_cnt) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = (r_state == ST_RUN) && (r_remaining != '0) && (w_occ < 3'd2);

    stream_skid_fifo2 #(
        .W(DW + 1)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_inflight),
        .i_din  ({r_inflight_last, rd_dout}),
        .i_pop  (w_pop),
        .o_valid(w_valid),
        .o_dout (w_head),
        .o_cnt  (w_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == (AW+1)'(1));
            if (w_issue) begin
                r_addr      <= r_addr + AW'(1);
                r_remaining <= r_remaining - (AW+1)'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_addr      <= base_addr;
                            r_remaining <= len;
                            r_busy      <= 1'b1;
                            r_state     <= ST_RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_remaining == '0) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // The tagged word is the final one, so its handshake empties the pipe.
                    if (w_pop && w_head[DW]) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_addr = r_addr;
    assign m_valid = w_valid;
    assign m_data  = w_head[DW-1:0];
    assign m_last  = w_head[DW];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench: BRAM model, queue-based window reference, per-cycle stream checker.
module tb_bram_stream_reader;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 36;
    localparam int unsigned DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_dout = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;

    bram_stream_reader #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_dout  (rd_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:DEPTH-1];
    always @(posedge clk) rd_dout <= ram[rd_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } ent_t;
    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        logic          l;
    } log_t;

    ent_t exp_q[$];
    log_t got_q[$];

    // Reference model state
    int            cyc = 0;
    bit            m_busy = 0;
    bit            exp_done = 0;
    bit            first_seen = 0;
    int            start_cyc = 0;
    int            popped = 0;
    logic [AW-1:0] cur_base = '0;
    bit            prev_valid = 0;
    bit            prev_ready = 0;
    logic [DW-1:0] prev_data = '0;
    bit            prev_last = 0;
    int            done_cnt = 0;
    int            last_done_cyc = 0;
    int            last_start_cyc = 0;

    always @(negedge clk) begin
        bit            nxt_done;
        bit            nxt_busy;
        logic [AW-1:0] occ;
        if (!rst_n) begin
            exp_q.delete();
            m_busy     = 0;
            exp_done   = 0;
            prev_valid = 0;
        end else begin
            cyc++;
            nxt_done = 0;
            nxt_busy = m_busy;
            chk("done", done, exp_done);
            chk("busy", busy, m_busy);
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (m_busy) begin
                occ = rd_addr - cur_base - AW'(popped);
                chk("outstanding_le2", occ <= 2, 1);
            end
            if (prev_valid && !prev_ready) begin
                chk("valid_held", m_valid, 1);
                chk("data_stable", m_data, prev_data);
                chk("last_stable", m_last, prev_last);
            end
            if (m_valid) begin
                if (!first_seen) begin
                    first_seen = 1;
                    chk("first_latency", cyc - start_cyc, 3);
                end
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", m_valid, 0);
                end else begin
                    chk("data", m_data, exp_q[0].d);
                    chk("last", m_last, exp_q[0].l);
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        popped++;
                        got_q.push_back('{cyc, m_data, m_last});
                        if (exp_q.size() == 0) begin
                            nxt_done = 1;
                            nxt_busy = 0;
                        end
                    end
                end
            end
            if (start && !m_busy) begin
                last_start_cyc = cyc;
                if (len == 0) begin
                    nxt_done = 1;
                end else begin
                    nxt_busy   = 1;
                    cur_base   = base_addr;
                    popped     = 0;
                    start_cyc  = cyc;
                    first_seen = 0;
                    for (int k = 0; k < int'(len); k++)
                        exp_q.push_back('{ram[AW'(int'(base_addr) + k)], k == int'(len) - 1});
                end
            end
            exp_done   = nxt_done;
            m_busy     = nxt_busy;
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic run(input logic [AW-1:0] b, input logic [AW:0] l, input int mode, input bit mid);
        int d0;
        int k;
        d0 = done_cnt;
        start = 1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 0;
        k = 0;
        while (done_cnt == d0 && k < 6000) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = k[0];
                2:       m_ready = ($urandom_range(0, 3) != 0);
                default: m_ready = (k < 10) ? k[0] : (k < 15) ? 1'b0 : 1'b1;
            endcase
            if (mid && k == 4) begin
                start = 1; base_addr = 11'd500; len = 12'd7;
            end else begin
                start = 0;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 0;
        if (done_cnt == d0) chk("run_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int i0;
        int d0;
        for (int i = 0; i < int'(DEPTH); i++)
            ram[i] = {25'((i * 7) ^ 'h1A5A5A5), 11'(i)};

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;

        // Back-to-back window of 8 with the consumer always ready
        i0 = got_q.size();
        run(11'd0, 12'd8, 0, 0);
        chk("t1_count", got_q.size() - i0, 8);
        if (got_q.size() - i0 == 8) begin
            chk("t1_latency", got_q[i0].cyc - last_start_cyc, 3);
            for (int k = 0; k < 8; k++) begin
                chk("t1_word", got_q[i0 + k].d[10:0], k);
                chk("t1_cycle", got_q[i0 + k].cyc - got_q[i0].cyc, k);
                chk("t1_lastflag", got_q[i0 + k].l, k == 7);
            end
            chk("t1_done_cyc", last_done_cyc - got_q[i0 + 7].cyc, 1);
        end

        // Window wraps past the top of the BRAM
        i0 = got_q.size();
        run(11'd2046, 12'd4, 0, 0);
        chk("t2_count", got_q.size() - i0, 4);
        if (got_q.size() - i0 == 4) begin
            chk("t2_w0", got_q[i0].d[10:0], 2046);
            chk("t2_w1", got_q[i0 + 1].d[10:0], 2047);
            chk("t2_w2", got_q[i0 + 2].d[10:0], 0);
            chk("t2_w3", got_q[i0 + 3].d[10:0], 1);
            chk("t2_w3_last", got_q[i0 + 3].l, 1);
            chk("t2_w2_last", got_q[i0 + 2].l, 0);
        end

        // Toggling then stalled consumer
        i0 = got_q.size();
        run(11'd100, 12'd16, 3, 0);
        chk("t3_count", got_q.size() - i0, 16);
        if (got_q.size() - i0 == 16) begin
            chk("t3_first", got_q[i0].d[10:0], 100);
            chk("t3_final", got_q[i0 + 15].d[10:0], 115);
        end

        // Empty window
        i0 = got_q.size();
        d0 = done_cnt;
        run(11'd33, 12'd0, 0, 0);
        chk("t4_count", got_q.size() - i0, 0);
        chk("t4_done_pulses", done_cnt - d0, 1);

        // Start during a sweep is ignored
        i0 = got_q.size();
        run(11'd40, 12'd12, 1, 1);
        chk("t5_count", got_q.size() - i0, 12);
        if (got_q.size() - i0 == 12) begin
            chk("t5_first", got_q[i0].d[10:0], 40);
            chk("t5_final", got_q[i0 + 11].d[10:0], 51);
        end

        // Asynchronous reset after three words of a ten-word sweep
        i0 = got_q.size();
        d0 = done_cnt;
        start = 1; base_addr = 11'd0; len = 12'd10; m_ready = 1;
        @(posedge clk); #1;
        start = 0;
        for (int k = 0; k < 50 && (got_q.size() - i0) < 3; k++) begin
            @(posedge clk); #1;
        end
        chk("t6_three_words", got_q.size() - i0, 3);
        #2 rst_n = 0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_valid", m_valid, 0);
        chk("t6_addr", rd_addr, 0);
        chk("t6_data", m_data, 0);
        chk("t6_last", m_last, 0);
        @(posedge clk); #2 rst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt - d0, 0);
        i0 = got_q.size();
        run(11'd0, 12'd2, 0, 0);
        chk("t6_count", got_q.size() - i0, 2);
        if (got_q.size() - i0 == 2) begin
            chk("t6_w0", got_q[i0].d[10:0], 0);
            chk("t6_w1", got_q[i0 + 1].d[10:0], 1);
        end

        // Randomised windows and backpressure
        for (int n = 0; n < 25; n++) begin
            logic [AW-1:0] b;
            logic [AW:0]   l;
            b = AW'($urandom_range(0, DEPTH - 1));
            l = ($urandom_range(0, 9) == 0) ? '0 : (AW+1)'($urandom_range(1, 40));
            run(b, l, 2, 0);
        end
        run(AW'($urandom_range(0, DEPTH - 1)), 12'd2048, 0, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
